// File: rtl/ewtag_counter.sv
// ewtag_counter: running Event Window tag generator.
// Loads a start offset on run_start, advances on every Event Window Marker,
// watches for EWM dropouts and cross-checks DTC heartbeat tags.
module ewtag_counter #(
  parameter int TAG_BITS    = 48,
  parameter int TIMEOUT_CYC = 20000,
  parameter int ERR_BITS    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run_start,
  input  logic                run_stop,
  input  logic [TAG_BITS-1:0] ewtag_offset,
  input  logic                ewm,
  input  logic                hb_valid,
  input  logic [TAG_BITS-1:0] hb_tag,
  output logic [TAG_BITS-1:0] ewtag,
  output logic                ewtag_valid,
  output logic                running,
  output logic                ewm_timeout,
  output logic                hb_mismatch,
  output logic [ERR_BITS-1:0] hb_err_cnt
);

  localparam int WD_BITS = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_BITS-1:0] WD_MAX  = WD_BITS'(TIMEOUT_CYC);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t              state_q, state_d;
  logic [TAG_BITS-1:0] tag_next;
  logic [WD_BITS-1:0]  wd_q;
  logic                ewm_acc;   // EWM that actually advances the tag
  logic                hb_bad;    // heartbeat disagrees with current tag

  // Next-state: run_start always wins and drops a coincident EWM; an EWM
  // coinciding with run_stop is still processed before going idle.
  always_comb begin
    state_d = state_q;
    ewm_acc = 1'b0;
    case (state_q)
      IDLE: if (run_start) state_d = ARMED;
      ARMED, RUN: begin
        if (run_start) begin
          state_d = ARMED;
        end else begin
          ewm_acc = ewm;
          if (run_stop) state_d = IDLE;
          else if (ewm) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Heartbeat compares against the tag registered before any same-cycle EWM.
  assign hb_bad  = (state_q == RUN) && hb_valid && (hb_tag != ewtag);
  assign running = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Tag load/advance and the one-cycle update/mismatch pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ewtag       <= '0;
      tag_next    <= '0;
      ewtag_valid <= 1'b0;
      hb_mismatch <= 1'b0;
    end else begin
      ewtag_valid <= ewm_acc;
      hb_mismatch <= hb_bad;
      if (run_start) begin
        tag_next <= ewtag_offset;
      end else if (ewm_acc) begin
        ewtag    <= tag_next;
        tag_next <= tag_next + TAG_BITS'(1);
      end
    end
  end

  // Saturating heartbeat error count, cleared by each run_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         hb_err_cnt <= '0;
    else if (run_start)                   hb_err_cnt <= '0;
    else if (hb_bad && (hb_err_cnt != '1)) hb_err_cnt <= hb_err_cnt + ERR_BITS'(1);
  end

  // EWM watchdog: counts RUN cycles without an EWM, saturates at the limit
  // and latches a sticky timeout when the limit is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q        <= '0;
      ewm_timeout <= 1'b0;
    end else if (run_start) begin
      wd_q        <= '0;
      ewm_timeout <= 1'b0;
    end else if (state_q == RUN) begin
      if (ewm) begin
        wd_q <= '0;
      end else if (wd_q != WD_MAX) begin
        wd_q <= wd_q + WD_BITS'(1);
        if (wd_q == WD_LAST) ewm_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ewtag_counter.sv
// Randomized + directed bench for ewtag_counter against a cycle-level
// behavioural model of the run/tag/heartbeat rules.
module tb_ewtag_counter;
  localparam int TAG = 48;
  localparam int TO  = 100;
  localparam int EB  = 2;
  localparam longint MASK    = (64'd1 << TAG) - 1;
  localparam int     ERR_MAX = (1 << EB) - 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           run_start, run_stop, ewm, hb_valid;
  logic [TAG-1:0] ewtag_offset, hb_tag;
  logic [TAG-1:0] ewtag;
  logic           ewtag_valid, running, ewm_timeout, hb_mismatch;
  logic [EB-1:0]  hb_err_cnt;

  ewtag_counter #(.TAG_BITS(TAG), .TIMEOUT_CYC(TO), .ERR_BITS(EB)) dut (
    .clk(clk), .reset_n(reset_n), .run_start(run_start), .run_stop(run_stop),
    .ewtag_offset(ewtag_offset), .ewm(ewm), .hb_valid(hb_valid), .hb_tag(hb_tag),
    .ewtag(ewtag), .ewtag_valid(ewtag_valid), .running(running),
    .ewm_timeout(ewm_timeout), .hb_mismatch(hb_mismatch), .hb_err_cnt(hb_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: mode 0 = idle, 1 = armed, 2 = run.
  int     m_mode, m_wd, m_cnt;
  longint m_tag, m_next;
  bit     m_vld, m_mis, m_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wd = 0; m_cnt = 0; m_tag = 0; m_next = 0;
    m_vld = 0; m_mis = 0; m_to = 0;
  endtask

  task automatic model_step();
    longint old_tag = m_tag;
    bit act = (m_mode != 0);
    m_vld = 0;
    m_mis = (m_mode == 2) && hb_valid && (longint'(hb_tag) != old_tag);
    if (run_start) begin
      m_mode = 1; m_next = longint'(ewtag_offset); m_cnt = 0; m_to = 0; m_wd = 0;
    end else if (act) begin
      if (m_mode == 2) begin
        if (ewm) m_wd = 0; else m_wd++;
        if (m_wd >= TO) m_to = 1;
      end
      if (m_mis) m_cnt = (m_cnt == ERR_MAX) ? ERR_MAX : m_cnt + 1;
      if (ewm) begin
        m_tag = m_next; m_next = (m_next + 1) & MASK; m_vld = 1;
      end
      if (run_stop) m_mode = 0;
      else if (ewm) m_mode = 2;
    end
  endtask

  task automatic check_all();
    chk("ewtag", 64'(ewtag), 64'(m_tag));
    chk("ewtag_valid", 64'(ewtag_valid), 64'(m_vld));
    chk("running", 64'(running), 64'(m_mode != 0));
    chk("ewm_timeout", 64'(ewm_timeout), 64'(m_to));
    chk("hb_mismatch", 64'(hb_mismatch), 64'(m_mis));
    chk("hb_err_cnt", 64'(hb_err_cnt), 64'(m_cnt));
  endtask

  // One clock: drive inputs, let the edge happen, compare on the falling edge.
  task automatic step(input bit rs, input bit rp, input bit e, input bit hv,
                      input logic [TAG-1:0] ht, input logic [TAG-1:0] off);
    run_start = rs; run_stop = rp; ewm = e; hb_valid = hv;
    hb_tag = ht; ewtag_offset = off;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    run_start = 0; run_stop = 0; ewm = 0; hb_valid = 0; hb_tag = '0; ewtag_offset = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Basic run from offset 0x100.
    step(1, 0, 0, 0, '0, 48'h100);
    chk("armed_running", 64'(running), 64'd1);
    step(0, 0, 1, 0, '0, '0);
    chk("t1_tag0", 64'(ewtag), 64'h100);
    chk("t1_vld0", 64'(ewtag_valid), 64'd1);
    idle(1);
    chk("t1_vld_drop", 64'(ewtag_valid), 64'd0);
    step(0, 0, 1, 0, '0, '0);
    step(0, 0, 1, 0, '0, '0);
    chk("t1_tag2", 64'(ewtag), 64'h102);
    idle(1);

    // Tag wrap at all-ones.
    step(1, 0, 0, 0, '0, 48'hFFFF_FFFF_FFFE);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0, '0);
    chk("t2_wrap", 64'(ewtag), 64'h0);
    chk("t2_noflag", 64'(ewm_timeout), 64'd0);

    // Watchdog timeout, sticky through EWMs, cleared by run_start.
    idle(TO - 1);
    chk("t3_before", 64'(ewm_timeout), 64'd0);
    idle(1);
    chk("t3_set", 64'(ewm_timeout), 64'd1);
    step(0, 0, 1, 0, '0, '0);
    step(0, 0, 1, 0, '0, '0);
    chk("t3_sticky", 64'(ewm_timeout), 64'd1);
    step(1, 0, 0, 0, '0, 48'h200);
    chk("t3_clear", 64'(ewm_timeout), 64'd0);

    // Heartbeat check and saturating error count.
    step(0, 0, 1, 0, '0, '0);
    step(0, 0, 0, 1, 48'h200, '0);
    chk("t4_match", 64'(hb_mismatch), 64'd0);
    step(0, 0, 0, 1, 48'h1FF, '0);
    chk("t4_mis", 64'(hb_mismatch), 64'd1);
    chk("t4_cnt1", 64'(hb_err_cnt), 64'd1);
    idle(1);
    chk("t4_pulse", 64'(hb_mismatch), 64'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 48'h1FF, '0);
    chk("t4_sat", 64'(hb_err_cnt), 64'd3);
    step(0, 0, 1, 1, 48'h201, '0);  // check uses pre-update tag 0x200
    chk("t4_preupd", 64'(hb_mismatch), 64'd1);

    // Same-cycle run_start + ewm, then run_stop + ewm.
    step(1, 0, 1, 0, '0, 48'h500);
    chk("t5_noval", 64'(ewtag_valid), 64'd0);
    step(0, 0, 1, 0, '0, '0);
    chk("t5_tag", 64'(ewtag), 64'h500);
    step(0, 1, 1, 0, '0, '0);
    chk("t5_final", 64'(ewtag_valid), 64'd1);
    chk("t5_idle", 64'(running), 64'd0);
    step(0, 0, 1, 0, '0, '0);
    chk("t5_hold", 64'(ewtag), 64'h501);

    // Asynchronous reset mid-run.
    step(1, 0, 0, 0, '0, 48'h42);
    step(0, 0, 1, 0, '0, '0);
    step(0, 0, 1, 0, '0, '0);
    @(posedge clk);
    model_step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 1, 0, '0, '0);
    chk("t6_ignored", 64'(ewtag_valid), 64'd0);

    // Randomized traffic with occasional EWM-free stretches.
    for (int i = 0; i < 3000; i++) begin
      bit quiet = ((i / 250) % 4) == 3;
      bit rs = ($urandom_range(99) < 3);
      bit rp = ($urandom_range(99) < 3);
      bit e  = !quiet && ($urandom_range(99) < 30);
      bit hv = ($urandom_range(99) < 20);
      logic [TAG-1:0] ht, off;
      case ($urandom_range(3))
        0, 1: ht = TAG'(m_tag);
        2:    ht = TAG'((m_tag + 1) & MASK);
        default: ht = {16'($urandom), 32'($urandom)};
      endcase
      off = ($urandom_range(1) == 1) ? {16'hFFFF, 32'hFFFF_FFFF - 32'($urandom_range(3))}
                                     : {16'($urandom), 32'($urandom)};
      step(rs, rp, e, hv, ht, off);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
